slink_bist_tx: RTL and testbench

BIST packet generator for the S-Link application-layer transmit path. When enabled, it emits a continuous stream of back-to-back packets with deterministic data ID, word count and payload. The stream is exactly what the receive-side BIST checker expects, configured from the same swi_bist_* register fields. It sits in front of the link-layer TX application interface and is muxed in place of user traffic while BIST is active.

---
 rtl/slink_bist_tx.sv | 200 ++++++++++++++++++++
 tb/tb_slink_bist_tx.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slink_bist_tx.sv
// slink_bist_tx: BIST packet generator for the S-Link application TX path.
// Emits back-to-back packets whose data ID, word count and payload follow the
// swi_bist_* configuration, matching what the receive-side BIST checker expects.
//
// state   | meaning
// IDLE    | generator off, no beats presented
// SOP     | presenting first beat (header + payload bytes 0..N-1)
// PAYLOAD | presenting continuation beats starting at r_byte_off
//
// Payload select encodings (mirrors BIST_PAYLOAD_* in slink_includes.vh):
//   4'h0 -> 0xAA (1010), 4'h1 -> 0xCC (1100), 4'h2 -> 0xF0 (1111_0000),
//   4'h3 -> byte index counter, anything else -> 0xD0.
module slink_bist_tx #(
  parameter  int APP_DATA_WIDTH = 32,
  localparam int APP_DATA_BYTES = APP_DATA_WIDTH >> 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      swi_bist_en,
  input  logic [3:0]                swi_bist_mode_payload,
  input  logic                      swi_bist_mode_wc,
  input  logic [15:0]               swi_bist_wc_min,
  input  logic [15:0]               swi_bist_wc_max,
  input  logic                      swi_bist_mode_di,
  input  logic [7:0]                swi_bist_di_min,
  input  logic [7:0]                swi_bist_di_max,
  output logic                      sop,
  output logic [7:0]                data_id,
  output logic [15:0]               word_count,
  output logic [APP_DATA_WIDTH-1:0] app_data,
  output logic                      valid,
  input  logic                      advance,
  output logic                      bist_active,
  output logic [15:0]               bist_pkt_count
);

  localparam logic [3:0]  PAYLOAD_1010     = 4'h0;
  localparam logic [3:0]  PAYLOAD_1100     = 4'h1;
  localparam logic [3:0]  PAYLOAD_11110000 = 4'h2;
  localparam logic [3:0]  PAYLOAD_COUNT    = 4'h3;
  localparam logic [16:0] BEAT_BYTES       = 17'(APP_DATA_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SOP     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_en_meta, r_en_s;
  logic [15:0] r_cur_wc, w_cur_wc_nxt;
  logic [7:0]  r_cur_di, w_cur_di_nxt;
  logic [3:0]  r_payload, w_payload_nxt;
  logic [16:0] r_byte_off, w_byte_off_nxt;
  logic [15:0] r_pkt_count, w_pkt_count_nxt;
  logic        w_pkt_done;
  logic [16:0] w_beat_base;
  logic [16:0] w_cur_wc_ext;

  // Byte value for absolute payload index k; bytes past the word count are zero.
  function automatic logic [7:0] pattern_byte(input logic [3:0] code,
                                               input logic [16:0] k,
                                               input logic [16:0] wc);
    logic [7:0] b;
    if (k >= wc) begin
      b = 8'h00;
    end else begin
      case (code)
        PAYLOAD_1010:     b = 8'hAA;
        PAYLOAD_1100:     b = 8'hCC;
        PAYLOAD_11110000: b = 8'hF0;
        PAYLOAD_COUNT:    b = k[7:0];
        default:          b = 8'hD0;
      endcase
    end
    return b;
  endfunction

  assign w_cur_wc_ext = {1'b0, r_cur_wc};
  assign w_beat_base  = (r_state == ST_PAYLOAD) ? r_byte_off : 17'd0;

  // Two-flop synchronizer for the asynchronous enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en_meta <= 1'b0;
      r_en_s    <= 1'b0;
    end else begin
      r_en_meta <= swi_bist_en;
      r_en_s    <= r_en_meta;
    end
  end

  // State and packet-context registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cur_wc    <= 16'd0;
      r_cur_di    <= 8'd0;
      r_payload   <= 4'd0;
      r_byte_off  <= 17'd0;
      r_pkt_count <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_wc    <= w_cur_wc_nxt;
      r_cur_di    <= w_cur_di_nxt;
      r_payload   <= w_payload_nxt;
      r_byte_off  <= w_byte_off_nxt;
      r_pkt_count <= w_pkt_count_nxt;
    end
  end

  // Next-state: packet sequencing, boundary-only config sampling, wc/di stepping.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_wc_nxt    = r_cur_wc;
    w_cur_di_nxt    = r_cur_di;
    w_payload_nxt   = r_payload;
    w_byte_off_nxt  = r_byte_off;
    w_pkt_count_nxt = r_pkt_count;
    w_pkt_done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_en_s) begin
          w_cur_wc_nxt    = swi_bist_wc_min;
          w_cur_di_nxt    = swi_bist_di_min;
          w_payload_nxt   = swi_bist_mode_payload;
          w_byte_off_nxt  = 17'd0;
          w_pkt_count_nxt = 16'd0;
          w_state_nxt     = ST_SOP;
        end
      end
      ST_SOP: begin
        if (advance) begin
          if (w_cur_wc_ext <= BEAT_BYTES) begin
            w_pkt_done = 1'b1;
          end else begin
            w_byte_off_nxt = BEAT_BYTES;
            w_state_nxt    = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (advance) begin
          // Last-beat test uses the offset of the beat being accepted.
          if (r_byte_off + BEAT_BYTES >= w_cur_wc_ext) begin
            w_pkt_done = 1'b1;
          end else begin
            w_byte_off_nxt = r_byte_off + BEAT_BYTES;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_pkt_done) begin
      if (r_pkt_count != 16'hFFFF) begin
        w_pkt_count_nxt = r_pkt_count + 16'd1;
      end
      if (!swi_bist_mode_wc) begin
        w_cur_wc_nxt = swi_bist_wc_min;
      end else if (r_cur_wc == swi_bist_wc_max) begin
        w_cur_wc_nxt = swi_bist_wc_min;
      end else begin
        w_cur_wc_nxt = r_cur_wc + 16'd1;
      end
      if (!swi_bist_mode_di) begin
        w_cur_di_nxt = swi_bist_di_min;
      end else if (r_cur_di == swi_bist_di_max) begin
        w_cur_di_nxt = swi_bist_di_min;
      end else begin
        w_cur_di_nxt = r_cur_di + 8'd1;
      end
      w_payload_nxt  = swi_bist_mode_payload;
      w_byte_off_nxt = 17'd0;
      w_state_nxt    = r_en_s ? ST_SOP : ST_IDLE;
    end
  end

  // Beat outputs decoded from registered context so they hold while stalled.
  always_comb begin
    valid          = (r_state != ST_IDLE);
    sop            = (r_state == ST_SOP);
    bist_active    = (r_state != ST_IDLE);
    bist_pkt_count = r_pkt_count;
    data_id        = 8'd0;
    word_count     = 16'd0;
    app_data       = '0;
    if (r_state == ST_SOP) begin
      data_id    = r_cur_di;
      word_count = r_cur_wc;
    end
    if (r_state != ST_IDLE) begin
      for (int i = 0; i < APP_DATA_BYTES; i++) begin
        app_data[8*i +: 8] = pattern_byte(r_payload, w_beat_base + 17'(i), w_cur_wc_ext);
      end
    end
  end

endmodule

// File: tb/tb_slink_bist_tx.sv
// Bench for slink_bist_tx: packet-level reference model checked on every
// accepted beat and every stalled cycle, plus literal expectations per scenario.
module tb_slink_bist_tx;
  localparam int W = 32;
  localparam int N = W / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          swi_bist_en = 1'b0;
  logic [3:0]    swi_bist_mode_payload = 4'h0;
  logic          swi_bist_mode_wc = 1'b0;
  logic [15:0]   swi_bist_wc_min = 16'd0;
  logic [15:0]   swi_bist_wc_max = 16'd0;
  logic          swi_bist_mode_di = 1'b0;
  logic [7:0]    swi_bist_di_min = 8'd0;
  logic [7:0]    swi_bist_di_max = 8'd0;
  logic          advance = 1'b0;
  logic          sop, valid, bist_active;
  logic [7:0]    data_id;
  logic [15:0]   word_count, bist_pkt_count;
  logic [W-1:0]  app_data;

  slink_bist_tx #(.APP_DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .swi_bist_en(swi_bist_en),
    .swi_bist_mode_payload(swi_bist_mode_payload), .swi_bist_mode_wc(swi_bist_mode_wc),
    .swi_bist_wc_min(swi_bist_wc_min), .swi_bist_wc_max(swi_bist_wc_max),
    .swi_bist_mode_di(swi_bist_mode_di), .swi_bist_di_min(swi_bist_di_min),
    .swi_bist_di_max(swi_bist_di_max), .sop(sop), .data_id(data_id),
    .word_count(word_count), .app_data(app_data), .valid(valid), .advance(advance),
    .bist_active(bist_active), .bist_pkt_count(bist_pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sop;
    logic [7:0]   di;
    logic [15:0]  wc;
    logic [W-1:0] d;
  } beat_t;

  beat_t log_q[$];
  beat_t m_b;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired", name);
  endtask

  // Reference: what byte k of a wc-byte packet must be.
  function automatic logic [7:0] exp_byte(input logic [3:0] code, input int k, input int wc);
    if (k >= wc) return 8'h00;
    case (code)
      4'h0: return 8'hAA;
      4'h1: return 8'hCC;
      4'h2: return 8'hF0;
      4'h3: return 8'(k % 256);
      default: return 8'hD0;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_data(input logic [3:0] code, input int off, input int wc);
    logic [W-1:0] d;
    for (int i = 0; i < N; i++) d[8*i +: 8] = exp_byte(code, off + i, wc);
    return d;
  endfunction

  // Model state: current packet's wc/di, bytes already sent, packets completed.
  logic [15:0]  m_wc;
  logic [7:0]   m_di;
  logic [3:0]   m_code;
  int           m_off = 0;
  int           m_cnt = 0;
  bit           m_prev_active = 0;
  bit           m_hold = 0;
  logic         p_sop;
  logic [7:0]   p_di;
  logic [15:0]  p_wc;
  logic [W-1:0] p_d;

  // Compare process: every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      m_prev_active = 0;
      m_hold = 0;
    end else begin
      if (bist_active && !m_prev_active) begin
        m_wc = swi_bist_wc_min;
        m_di = swi_bist_di_min;
        m_code = swi_bist_mode_payload;
        m_off = 0;
        m_cnt = 0;
        m_hold = 0;
      end
      if (bist_active) begin
        check("valid_when_active", 64'(valid), 64'(1));
        check("pkt_count", 64'(bist_pkt_count), 64'(m_cnt));
        if (m_hold) begin
          check("stall_sop", 64'(sop), 64'(p_sop));
          check("stall_data_id", 64'(data_id), 64'(p_di));
          check("stall_word_count", 64'(word_count), 64'(p_wc));
          check("stall_app_data", 64'(app_data), 64'(p_d));
        end
        if (valid && advance) begin
          check("beat_sop", 64'(sop), 64'(m_off == 0));
          if (m_off == 0) begin
            check("beat_data_id", 64'(data_id), 64'(m_di));
            check("beat_word_count", 64'(word_count), 64'(m_wc));
          end
          check("beat_app_data", 64'(app_data), 64'(exp_data(m_code, m_off, int'(m_wc))));
          m_b.sop = sop; m_b.di = data_id; m_b.wc = word_count; m_b.d = app_data;
          log_q.push_back(m_b);
          m_off += N;
          if (m_off >= int'(m_wc)) begin
            if (m_cnt < 65535) m_cnt++;
            if (!swi_bist_mode_wc || m_wc == swi_bist_wc_max) m_wc = swi_bist_wc_min;
            else m_wc = m_wc + 16'd1;
            if (!swi_bist_mode_di || m_di == swi_bist_di_max) m_di = swi_bist_di_min;
            else m_di = m_di + 8'd1;
            m_code = swi_bist_mode_payload;
            m_off = 0;
          end
        end
        m_hold = valid && !advance;
        p_sop = sop; p_di = data_id; p_wc = word_count; p_d = app_data;
      end else begin
        check("valid_when_idle", 64'(valid), 64'(0));
        m_hold = 0;
      end
      m_prev_active = bist_active;
    end
  end

  // Advance driver: 0 = always, 1 = random, 2 = repeating 1-0-0-1.
  int adv_mode = 0;
  int adv_ph = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (adv_mode)
      0: advance = 1'b1;
      1: advance = ($urandom_range(0, 2) != 0);
      default: begin
        advance = (adv_ph == 0 || adv_ph == 3);
        adv_ph = (adv_ph + 1) % 4;
      end
    endcase
  end

  task automatic configure(input logic [3:0] code, input bit mwc, input logic [15:0] wmin,
                           input logic [15:0] wmax, input bit mdi, input logic [7:0] dmin,
                           input logic [7:0] dmax, input int amode);
    swi_bist_mode_payload = code;
    swi_bist_mode_wc = mwc; swi_bist_wc_min = wmin; swi_bist_wc_max = wmax;
    swi_bist_mode_di = mdi; swi_bist_di_min = dmin; swi_bist_di_max = dmax;
    adv_mode = amode;
    log_q.delete();
    m_cnt = 0;
  endtask

  task automatic wait_pkts(input int npk, input string name);
    for (int i = 0; i < 20000; i++) begin
      if (m_cnt >= npk) break;
      @(negedge clk);
    end
    if (m_cnt < npk) timeout(name);
  endtask

  task automatic stop_stream(input string name);
    swi_bist_en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bist_active) break;
    end
    if (bist_active) timeout(name);
    check({name, "_boundary"}, 64'(m_off), 64'(0));
    check({name, "_valid"}, 64'(valid), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic run_stream(input logic [3:0] code, input bit mwc, input logic [15:0] wmin,
                            input logic [15:0] wmax, input bit mdi, input logic [7:0] dmin,
                            input logic [7:0] dmax, input int amode, input int npk,
                            input string name);
    configure(code, mwc, wmin, wmax, mdi, dmin, dmax, amode);
    swi_bist_en = 1'b1;
    wait_pkts(npk, name);
    stop_stream(name);
  endtask

  task automatic check_log(input int idx, input string name, input logic sop_e,
                           input logic [W-1:0] d_e);
    if (log_q.size() <= idx) begin
      timeout({name, "_missing"});
    end else begin
      check({name, "_sop"}, 64'(log_q[idx].sop), 64'(sop_e));
      check({name, "_data"}, 64'(log_q[idx].d), 64'(d_e));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wc_seq [5];
    logic [7:0]  di_seq [5];
    int          nsop;

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_sop", 64'(sop), 64'(0));
    check("rst_active", 64'(bist_active), 64'(0));
    check("rst_count", 64'(bist_pkt_count), 64'(0));
    check("rst_app_data", 64'(app_data), 64'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // COUNT pattern, wc=10: three beats per packet.
    run_stream(4'h3, 0, 16'd10, 16'd10, 0, 8'h12, 8'h12, 0, 4, "s1");
    check_log(0, "s1_b0", 1'b1, 32'h03020100);
    check_log(1, "s1_b1", 1'b0, 32'h07060504);
    check_log(2, "s1_b2", 1'b0, 32'h00000908);
    check_log(3, "s1_b3", 1'b1, 32'h03020100);
    if (log_q.size() > 0) begin
      check("s1_data_id", 64'(log_q[0].di), 64'(8'h12));
      check("s1_word_count", 64'(log_q[0].wc), 64'(16'd10));
    end else timeout("s1_empty");

    // Stepping word count and data ID.
    run_stream(4'h3, 1, 16'd4, 16'd6, 1, 8'h20, 8'h21, 0, 5, "s2");
    wc_seq = '{16'd4, 16'd5, 16'd6, 16'd4, 16'd5};
    di_seq = '{8'h20, 8'h21, 8'h20, 8'h21, 8'h20};
    nsop = 0;
    foreach (log_q[i]) begin
      if (log_q[i].sop && nsop < 5) begin
        check("s2_wc_seq", 64'(log_q[i].wc), 64'(wc_seq[nsop]));
        check("s2_di_seq", 64'(log_q[i].di), 64'(di_seq[nsop]));
        nsop++;
      end
    end
    check("s2_sop_count", 64'(nsop >= 5), 64'(1));

    // 1010 pattern, wc=8, advance 1-0-0-1.
    adv_ph = 0;
    run_stream(4'h0, 0, 16'd8, 16'd8, 0, 8'h05, 8'h05, 2, 3, "s3");
    check_log(0, "s3_b0", 1'b1, 32'hAAAAAAAA);
    check_log(1, "s3_b1", 1'b0, 32'hAAAAAAAA);
    check_log(2, "s3_b2", 1'b1, 32'hAAAAAAAA);
    check("s3_even_beats", 64'(log_q.size() % 2), 64'(0));

    // Disable mid-packet, then re-enable restarts at min values.
    configure(4'h3, 1, 16'd12, 16'd20, 1, 8'h07, 8'h09, 0);
    swi_bist_en = 1'b1;
    wait_pkts(1, "s4_first");
    for (int i = 0; i < 200; i++) begin
      if (m_off == N && valid && !sop) break;
      @(negedge clk);
    end
    stop_stream("s4_stop");
    configure(4'h3, 1, 16'd12, 16'd20, 1, 8'h07, 8'h09, 0);
    swi_bist_en = 1'b1;
    wait_pkts(1, "s4_restart");
    @(posedge clk);
    #1;
    check("s4_restart_count", 64'(bist_pkt_count), 64'(1));
    if (log_q.size() > 0) begin
      check("s4_restart_wc", 64'(log_q[0].wc), 64'(16'd12));
      check("s4_restart_di", 64'(log_q[0].di), 64'(8'h07));
    end else timeout("s4_restart_empty");
    stop_stream("s4_end");

    // Asynchronous reset mid-PAYLOAD.
    configure(4'h1, 1, 16'd16, 16'd18, 0, 8'h33, 8'h33, 0);
    swi_bist_en = 1'b1;
    wait_pkts(1, "s5_first");
    for (int i = 0; i < 200; i++) begin
      if (valid && !sop) break;
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    check("s5_valid", 64'(valid), 64'(0));
    check("s5_sop", 64'(sop), 64'(0));
    check("s5_data_id", 64'(data_id), 64'(0));
    check("s5_word_count", 64'(word_count), 64'(0));
    check("s5_app_data", 64'(app_data), 64'(0));
    check("s5_active", 64'(bist_active), 64'(0));
    check("s5_count", 64'(bist_pkt_count), 64'(0));
    repeat (2) @(negedge clk);
    log_q.delete();
    m_cnt = 0;
    reset = 1'b1;
    wait_pkts(1, "s5_after");
    if (log_q.size() > 0) begin
      check("s5_fresh_sop", 64'(log_q[0].sop), 64'(1));
      check("s5_fresh_wc", 64'(log_q[0].wc), 64'(16'd16));
    end else timeout("s5_fresh_empty");
    stop_stream("s5_end");

    // wc=0 and wc=2 with a default payload code.
    run_stream(4'hF, 0, 16'd0, 16'd0, 0, 8'h03, 8'h03, 0, 2, "s6");
    check_log(0, "s6_wc0_b0", 1'b1, 32'h00000000);
    check_log(1, "s6_wc0_b1", 1'b1, 32'h00000000);
    run_stream(4'hF, 0, 16'd2, 16'd2, 0, 8'h03, 8'h03, 0, 2, "s6b");
    check_log(0, "s6_wc2", 1'b1, 32'h0000D0D0);

    // Randomized configurations and flow control.
    for (int it = 0; it < 8; it++) begin
      logic [15:0] wmin;
      logic [7:0]  dmin;
      wmin = 16'($urandom_range(0, 20));
      dmin = 8'($urandom_range(0, 250));
      run_stream(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), wmin,
                 wmin + 16'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), dmin,
                 dmin + 8'($urandom_range(0, 5)), $urandom_range(0, 2), 6, "rnd");
    end
    // Long COUNT packets exercise the 256-byte wrap.
    run_stream(4'h3, 1, 16'd300, 16'd301, 0, 8'h44, 8'h44, 1, 3, "long");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
